fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the single-cycle/pipelined RV32I core. Holds the program counter, drives the combinational instruction-memory port (`im_addr` to `im_inst`) and registers each fetched word with its PC into a 2-entry buffer. The buffer feeds decode over a valid/ready handshake. It accepts redirects (taken branch or jump) from execute and halts permanently on a misaligned redirect target.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `NOP_INST`, default 32'h0000_0013: value driven on `id_inst` when the buffer is empty.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `im_addr` out 32: fetch address to instruction memory; always equals the PC register.
- `im_inst` in 32: instruction word, combinational from `im_addr`, valid in the same cycle.
- `redirect_valid` in 1: execute requests a PC change this cycle.
- `redirect_pc` in 32: redirect target.
- `id_valid` out 1: buffer head valid.
- `id_ready` in 1: decode accepts the head this cycle.
- `id_pc` out 32: PC of the head entry.
- `id_pc_plus4` out 32: `id_pc` + 4, modulo 2^32.
- `id_inst` out 32: instruction of the head entry.
- `fetch_halted` out 1: high in HALT state.

## Operation
- States are RUN and HALT. Reset enters RUN.
- pop = `id_valid` & `id_ready`.
- fetch = RUN & !`redirect_valid` & (count < 2 | pop).
- On fetch: push {PC, `im_inst`} at the tail; PC <= PC + 4. PC wraps from 32'hFFFF_FFFC to 32'h0000_0000 with no flag.
- On pop: advance the head. A simultaneous push and pop with count = 2 keeps count at 2.
- Redirect in RUN with `redirect_pc[1:0]` == 0:
  - Buffer flushed; count <= 0.
  - PC <= `redirect_pc`.
  - No push that cycle; the word at the old PC is discarded.
  - A simultaneous pop is still counted as consumed by decode, but the flush wins for buffer contents.
- Redirect in RUN with `redirect_pc[1:0]` != 0:
  - Transition to HALT; flush the buffer.
  - PC is left unchanged.
- HALT:
  - No fetch; `id_valid` = 0.
  - `redirect_valid` is ignored.
  - Only reset exits HALT.
- Empty buffer: `id_valid` = 0, `id_pc` = 0, `id_inst` = `NOP_INST`, `id_pc_plus4` = 4.
- Buffer storage: 2 entries, 1-bit head and tail pointers, 2-bit count (0..2).

## Timing
- Reset values:
  - PC = `RESET_PC`, so `im_addr` = `RESET_PC`.
  - count = 0, state = RUN.
  - `id_valid` = 0, `id_pc` = 0, `id_inst` = `NOP_INST`, `id_pc_plus4` = 4.
  - `fetch_halted` = 0.
- Reset assertion clears all state immediately, including mid-operation and in HALT.
- Fetch latency: a word fetched in cycle N is at the `id_*` outputs in cycle N+1. The first instruction is valid in the cycle after the first rising edge following `rst_n` release.
- Redirect latency: redirect in cycle N puts `im_addr` = target in N+1; the target instruction is at `id_*` in N+2. `id_valid` = 0 in N+1.
- Throughput: one instruction per cycle while `id_ready` is held high.
- Backpressure: with `id_ready` low, the buffer fills in 2 cycles, then PC holds. `id_*` must stay stable while `id_valid` & !`id_ready`.
- `fetch_halted` rises in the cycle after the misaligned redirect.
- All outputs come directly from registers or register-muxes. The only combinational input-to-output path is `im_inst` to the push data, which is internal.

## Structure
- Shared core package holds:
  - `RESET_PC` default and `NOP_INST` (32'h0000_0013).
  - Fetch state encoding: RUN = 1'b0, HALT = 1'b1.
  - A fetch-packet typedef {pc[31:0], inst[31:0]}.
- Sub-module `fetch_buf`: a 2-entry synchronous FIFO with push, pop and flush inputs, flush having priority. It reports count and head data.
- Top level holds the PC register, next-PC mux, state machine and `id_pc_plus4` adder.

## Test plan
- Reset, `RESET_PC` = 0, `id_ready` = 1, memory preloaded with words W0..W3: `id_pc` sequence 0, 4, 8, 12 with `id_inst` W0..W3 on consecutive cycles; `id_valid` = 1 from cycle 1.
- `id_ready` = 0 for 5 cycles after reset: count saturates at 2, `im_addr` holds at 8, `id_pc` holds at 0. After release, `id_pc` sequence is 0, 4, 8 with no gaps.
- Redirect to 0x40 while the buffer holds PCs 8 and 12: next cycle `id_valid` = 0 and `im_addr` = 0x40; the cycle after, `id_pc` = 0x40 and `id_pc_plus4` = 0x44. PCs 8 and 12 never appear.
- Redirect to 0x20 coinciding with a pop of PC 4: PC 4 is counted as consumed; the next valid `id_pc` is 0x20.
- Redirect to 0x22: `fetch_halted` = 1 next cycle and `id_valid` stays 0 for 10 cycles. A later redirect to 0x40 is ignored. Asserting `rst_n` low returns to PC 0 in RUN.
- PC at 32'hFFFF_FFF8 with `id_ready` = 1: `id_pc` sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; `id_pc_plus4` = 0 at FFFF_FFFC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: reset defaults,
// fetch state encoding and the fetch packet carried through the buffer.
package fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;  // addi x0, x0, 0

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_pkt_t;

endpackage

// File: rtl/fetch_unit_buf.sv
// Two-entry synchronous FIFO between fetch and decode. Flush has priority
// over push and pop; the caller never pushes when full without popping and
// never pops when empty.
module fetch_buf
    import fetch_unit_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  fetch_pkt_t push_data,
    input  logic       pop,
    input  logic       flush,
    output logic [1:0] count,
    output fetch_pkt_t head_data
);

    fetch_pkt_t mem [2];
    logic       head_ptr;
    logic       tail_ptr;

    // Storage, pointers and occupancy; flush empties the buffer outright.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0]   <= '0;
            mem[1]   <= '0;
            head_ptr <= 1'b0;
            tail_ptr <= 1'b0;
            count    <= 2'd0;
        end else if (flush) begin
            head_ptr <= 1'b0;
            tail_ptr <= 1'b0;
            count    <= 2'd0;
        end else begin
            if (push) begin
                mem[tail_ptr] <= push_data;
                tail_ptr      <= ~tail_ptr;
            end
            if (pop) begin
                head_ptr <= ~head_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head_data = mem[head_ptr];

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction fetch stage: PC register, next-PC selection, RUN/HALT
// state machine and the decode-facing view of the fetch buffer.
//
// Handshake to decode: id_valid means the id_* outputs hold a fetched
// instruction; the head is consumed on any rising edge where id_valid and
// id_ready are both high. While id_valid is high and id_ready is low the
// id_* outputs do not change (unless a redirect flushes the buffer).
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = fetch_unit_pkg::RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INST = fetch_unit_pkg::NOP_INST_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] im_addr,
    input  logic [31:0] im_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic [31:0] id_inst,
    output logic        fetch_halted
);

    fetch_state_e state;
    logic [31:0]  pc_q;
    logic [1:0]   buf_count;
    fetch_pkt_t   buf_head;
    fetch_pkt_t   push_pkt;
    logic         running;
    logic         pop;
    logic         fetch;
    logic         flush;
    logic         target_misaligned;

    assign running           = (state == ST_RUN);
    assign pop               = id_valid & id_ready;
    assign fetch             = running & ~redirect_valid & ((buf_count < 2'd2) | pop);
    // Any redirect seen in RUN discards buffered words, aligned or not.
    assign flush             = running & redirect_valid;
    assign target_misaligned = (redirect_pc[1:0] != 2'b00);
    assign push_pkt          = '{pc: pc_q, inst: im_inst};

    // State machine and PC register; HALT is left only through reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_RUN;
            pc_q         <= RESET_PC;
            fetch_halted <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (redirect_valid) begin
                        if (target_misaligned) begin
                            state        <= ST_HALT;
                            fetch_halted <= 1'b1;
                        end else begin
                            pc_q <= redirect_pc;
                        end
                    end else if (fetch) begin
                        pc_q <= pc_q + 32'd4;
                    end
                end
                ST_HALT: begin
                    fetch_halted <= 1'b1;
                end
            endcase
        end
    end

    fetch_buf u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fetch),
        .push_data (push_pkt),
        .pop       (pop),
        .flush     (flush),
        .count     (buf_count),
        .head_data (buf_head)
    );

    // Decode view: buffer head when occupied, a NOP at PC 0 when empty.
    always_comb begin
        id_valid = (buf_count != 2'd0);
        id_pc    = id_valid ? buf_head.pc : 32'd0;
        id_inst  = id_valid ? buf_head.inst : NOP_INST;
    end

    assign id_pc_plus4 = id_pc + 32'd4;
    assign im_addr     = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-level reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] im_addr;
    logic [31:0] im_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [31:0] id_inst;
    logic        fetch_halted;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: PCs waiting for decode, next fetch PC, halted flag.
    logic [31:0] exp_q[$];
    logic [31:0] m_pc = 32'd0;
    logic        m_halt = 1'b0;
    // PCs the DUT actually handed to decode.
    logic [31:0] acc_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .im_addr        (im_addr),
        .im_inst        (im_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4),
        .id_inst        (id_inst),
        .fetch_halted   (fetch_halted)
    );

    // Instruction memory contents: a word derived from its address.
    function automatic logic [31:0] inst_of(logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    assign im_inst = inst_of(im_addr);

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            m_pc   = 32'd0;
            m_halt = 1'b0;
        end else if (!m_halt) begin
            if (redirect_valid) begin
                exp_q.delete();
                if (redirect_pc[1:0] != 2'b00) m_halt = 1'b1;
                else m_pc = redirect_pc;
            end else begin
                if (exp_q.size() > 0 && id_ready) void'(exp_q.pop_front());
                if (exp_q.size() < 2) begin
                    exp_q.push_back(m_pc);
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    end

    // ---------------- scoreboard compare, every cycle ----------------
    always @(negedge clk) begin
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        e_pc   = (exp_q.size() > 0) ? exp_q[0] : 32'd0;
        e_inst = (exp_q.size() > 0) ? inst_of(exp_q[0]) : NOP;
        check("cmp_im_addr", im_addr, m_pc);
        check("cmp_id_valid", {31'd0, id_valid}, {31'd0, exp_q.size() > 0});
        check("cmp_id_pc", id_pc, e_pc);
        check("cmp_id_inst", id_inst, e_inst);
        check("cmp_id_pc_plus4", id_pc_plus4, e_pc + 32'd4);
        check("cmp_halted", {31'd0, fetch_halted}, {31'd0, m_halt});
    end

    // Record each accepted head just before the edge that consumes it.
    always @(negedge clk) begin
        #3;
        if (id_valid && id_ready) acc_q.push_back(id_pc);
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    task automatic do_reset(logic rdy);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        id_ready       = rdy;
        cyc(2);
        check("rst_im_addr", im_addr, 32'd0);
        check("rst_id_valid", {31'd0, id_valid}, 32'd0);
        check("rst_id_pc", id_pc, 32'd0);
        check("rst_id_inst", id_inst, NOP);
        check("rst_id_pc_plus4", id_pc_plus4, 32'd4);
        check("rst_halted", {31'd0, fetch_halted}, 32'd0);
        rst_n = 1'b1;
        acc_q.delete();
    endtask

    task automatic check_log(string name, int n, logic [31:0] e0, logic [31:0] e1,
                             logic [31:0] e2, logic [31:0] e3);
        logic [31:0] e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        check({name, "_len"}, acc_q.size(), n);
        for (int i = 0; i < n && i < acc_q.size(); i++)
            check({name, "_pc"}, acc_q[i], e[i]);
    endtask

    task automatic redirect(logic [31:0] tgt);
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        logic [39:0] pat;

        // Straight-line fetch with decode always ready.
        do_reset(1'b1);
        cyc(1);
        check("t1_valid", {31'd0, id_valid}, 32'd1);
        check("t1_pc0", id_pc, 32'h0);
        check("t1_w0", id_inst, 32'h0000_FFFF);
        cyc(1);
        check("t1_w1", id_inst, 32'h0004_FFFB);
        check("t1_pc1_plus4", id_pc_plus4, 32'h8);
        cyc(3);
        check_log("t1_seq", 4, 32'h0, 32'h4, 32'h8, 32'hC);

        // Backpressure: buffer fills, PC holds, then drains without gaps.
        do_reset(1'b0);
        cyc(6);
        check("t2_im_addr_hold", im_addr, 32'h8);
        check("t2_id_pc_hold", id_pc, 32'h0);
        check_log("t2_none", 0, 0, 0, 0, 0);
        id_ready = 1'b1;
        cyc(3);
        check_log("t2_seq", 3, 32'h0, 32'h4, 32'h8, 32'h0);

        // Redirect while the buffer holds PCs 8 and 12.
        do_reset(1'b1);
        cyc(3);
        id_ready = 1'b0;
        cyc(1);
        redirect(32'h40);
        cyc(1);
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        check("t3_valid_gap", {31'd0, id_valid}, 32'd0);
        check("t3_im_addr", im_addr, 32'h40);
        cyc(1);
        check("t3_id_pc", id_pc, 32'h40);
        check("t3_plus4", id_pc_plus4, 32'h44);
        cyc(1);
        check_log("t3_seq", 3, 32'h0, 32'h4, 32'h40, 32'h0);

        // Redirect in the same cycle PC 4 is consumed.
        do_reset(1'b1);
        cyc(2);
        redirect(32'h20);
        cyc(1);
        redirect_valid = 1'b0;
        check("t4_valid_gap", {31'd0, id_valid}, 32'd0);
        check("t4_im_addr", im_addr, 32'h20);
        cyc(1);
        check("t4_id_pc", id_pc, 32'h20);
        cyc(1);
        check_log("t4_seq", 3, 32'h0, 32'h4, 32'h20, 32'h0);

        // PC wrap at the top of the address space.
        do_reset(1'b1);
        cyc(1);
        redirect(32'hFFFF_FFF8);
        cyc(1);
        redirect_valid = 1'b0;
        cyc(1);
        check("t6_pc_f8", id_pc, 32'hFFFF_FFF8);
        check("t6_inst_f8", id_inst, 32'hFFF8_0007);
        cyc(1);
        check("t6_pc_fc", id_pc, 32'hFFFF_FFFC);
        check("t6_plus4_wrap", id_pc_plus4, 32'h0);
        cyc(1);
        check("t6_pc_0", id_pc, 32'h0);
        check("t6_valid_0", {31'd0, id_valid}, 32'd1);
        check_log("t6_seq", 3, 32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0);

        // Mixed ready pattern with a mid-stream redirect; model-checked.
        do_reset(1'b1);
        pat = 40'hB3_6C_F0_19_A7;
        for (int i = 0; i < 40; i++) begin
            id_ready       = pat[i];
            redirect_valid = (i == 17);
            redirect_pc    = 32'h100;
            cyc(1);
        end
        redirect_valid = 1'b0;
        id_ready       = 1'b1;

        // Misaligned redirect halts until reset.
        do_reset(1'b1);
        cyc(2);
        redirect(32'h22);
        cyc(1);
        redirect_valid = 1'b0;
        check("t5_halted", {31'd0, fetch_halted}, 32'd1);
        check("t5_valid", {31'd0, id_valid}, 32'd0);
        check("t5_pc_kept", im_addr, 32'h8);
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            check("t5_valid_hold", {31'd0, id_valid}, 32'd0);
        end
        redirect(32'h40);
        cyc(1);
        redirect_valid = 1'b0;
        check("t5_redirect_ignored", im_addr, 32'h8);
        check("t5_still_halted", {31'd0, fetch_halted}, 32'd1);
        cyc(1);
        rst_n = 1'b0;
        #1;
        check("t5_async_pc", im_addr, 32'h0);
        check("t5_async_halted", {31'd0, fetch_halted}, 32'd0);
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        check("t5_rerun_valid", {31'd0, id_valid}, 32'd1);
        check("t5_rerun_pc", id_pc, 32'h0);
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
